// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor control unit:
// opcodes, time-step encoding, IR field positions and the control bundle.
package proc_pkg;

   localparam int IR_OP_MSB = 9;
   localparam int IR_OP_LSB = 6;
   localparam int IR_X_MSB  = 5;
   localparam int IR_X_LSB  = 3;
   localparam int IR_Y_MSB  = 2;
   localparam int IR_Y_LSB  = 0;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_MVI  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_MVNZ = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3
   } tstep_e;

   // Raw per-cycle decode; register indices are resolved by the decoders.
   typedef struct packed {
      logic irin;
      logic rinEn;
      logic routEn;
      logic routY;
      logic ain;
      logic gin;
      logic gout;
      logic dinOut;
      logic sltOut;
      logic addSub;
      logic done;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic isAluOp(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Bundle between the control unit (master) and the datapath/board (slave):
// IR and flags in, register/ALU/bus controls and status out.
interface proc_control_unit_if #(
   parameter int IR_W     = 10,
   parameter int NUM_REGS = 8,
   parameter int CNT_W    = 16
);

   logic                Run;
   logic [IR_W-1:0]     IR;
   logic                Gnz;
   logic                IRin;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic                Ain;
   logic                Gin;
   logic                Gout;
   logic                DINout;
   logic                SltOut;
   logic                AddSub;
   logic                Done;
   logic [2:0]          Tstep;
   logic [CNT_W-1:0]    InstrCount;

   modport master (
      input  Run, IR, Gnz,
      output IRin, Rin, Rout, Ain, Gin, Gout, DINout, SltOut, AddSub,
             Done, Tstep, InstrCount
   );

   modport slave (
      output Run, IR, Gnz,
      input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, SltOut, AddSub,
             Done, Tstep, InstrCount
   );

endinterface

// File: rtl/proc_reg_decoder.sv
// 3-bit register index to one-hot enable vector; all-zero when not enabled.
module proc_reg_decoder #(
   parameter int NUM_REGS = 8
) (
   input  logic [2:0]          idx_i,
   input  logic                en_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/proc_control_unit.sv
// Multicycle control FSM: Tstep is the only state; every control is a
// combinational decode of Tstep, IR, Run and Gnz.
module proc_control_unit
   import proc_pkg::*;
#(
   parameter int IR_W     = 10,
   parameter int NUM_REGS = 8,
   parameter int CNT_W    = 16
) (
   input logic                  Clock,
   input logic                  Resetn,
   proc_control_unit_if.master  bus
);

   tstep_e           step_q, step_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [IR_W-1:0]  irVal;
   logic [3:0]       opcode;
   logic [2:0]       xIdx;
   logic [2:0]       yIdx;
   logic [2:0]       routIdx;
   ctrl_t            ctrlRaw;
   ctrl_t            ctrl;

   assign irVal   = bus.IR;
   assign opcode  = irVal[IR_OP_MSB:IR_OP_LSB];
   assign xIdx    = irVal[IR_X_MSB:IR_X_LSB];
   assign yIdx    = irVal[IR_Y_MSB:IR_Y_LSB];

   always_comb begin
      step_d  = T0;
      ctrlRaw = CTRL_IDLE;
      case (step_q)
         T0: begin
            if (bus.Run) begin
               ctrlRaw.irin = 1'b1;
               step_d       = T1;
            end
         end
         T1: begin
            if (isAluOp(opcode)) begin
               ctrlRaw.routEn = 1'b1;
               ctrlRaw.ain    = 1'b1;
               step_d         = T2;
            end else begin
               ctrlRaw.done = 1'b1;
               case (opcode)
                  OP_MV: begin
                     ctrlRaw.routEn = 1'b1;
                     ctrlRaw.routY  = 1'b1;
                     ctrlRaw.rinEn  = 1'b1;
                  end
                  OP_MVI: begin
                     ctrlRaw.dinOut = 1'b1;
                     ctrlRaw.rinEn  = 1'b1;
                  end
                  OP_MVNZ: begin
                     ctrlRaw.routEn = bus.Gnz;
                     ctrlRaw.routY  = 1'b1;
                     ctrlRaw.rinEn  = bus.Gnz;
                  end
                  default: ;
               endcase
            end
         end
         T2: begin
            ctrlRaw.routEn = 1'b1;
            ctrlRaw.routY  = 1'b1;
            ctrlRaw.gin    = 1'b1;
            ctrlRaw.addSub = (opcode != OP_ADD);
            step_d         = T3;
         end
         T3: begin
            ctrlRaw.rinEn  = 1'b1;
            ctrlRaw.done   = 1'b1;
            ctrlRaw.sltOut = (opcode == OP_SLT);
            ctrlRaw.gout   = (opcode != OP_SLT);
         end
         // Unreachable encodings fall back to T0 with every control low.
         default: ;
      endcase
   end

   // Controls stay low while Resetn is held even if Run is already high.
   always_comb begin
      ctrl    = Resetn ? ctrlRaw : CTRL_IDLE;
      routIdx = ctrl.routY ? yIdx : xIdx;
      count_d = ctrl.done ? count_q + CNT_W'(1) : count_q;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step_q  <= T0;
         count_q <= '0;
      end else begin
         step_q  <= step_d;
         count_q <= count_d;
      end
   end

   proc_reg_decoder #(.NUM_REGS(NUM_REGS)) uRinDec (
      .idx_i    (xIdx),
      .en_i     (ctrl.rinEn),
      .onehot_o (bus.Rin)
   );

   proc_reg_decoder #(.NUM_REGS(NUM_REGS)) uRoutDec (
      .idx_i    (routIdx),
      .en_i     (ctrl.routEn),
      .onehot_o (bus.Rout)
   );

   assign bus.IRin       = ctrl.irin;
   assign bus.Ain        = ctrl.ain;
   assign bus.Gin        = ctrl.gin;
   assign bus.Gout       = ctrl.gout;
   assign bus.DINout     = ctrl.dinOut;
   assign bus.SltOut     = ctrl.sltOut;
   assign bus.AddSub     = ctrl.addSub;
   assign bus.Done       = ctrl.done;
   assign bus.Tstep      = step_q;
   assign bus.InstrCount = count_q;

endmodule
